// File: rtl/mem_arbiter_if.sv
// One memory-port bundle: command toward the memory side, response back to the requester.
// The requesting side (a cache, or the arbiter toward memory) uses master; the serving side uses slave.
interface mem_arbiter_if #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128
);
    logic              read;
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ready;

    modport master (output read, output write, output addr, output wdata,
                    input  rdata, input  ready);
    modport slave  (input  read, input  write, input  addr, input  wdata,
                    output rdata, output ready);
endinterface

// File: rtl/mem_arbiter.sv
// Shares the single off-chip memory port between the I-cache and D-cache miss paths.
// One transaction at a time, round-robin on ties, with every output toward memory and the caches registered.
module mem_arbiter #(
    parameter int ADDR_W       = 28,
    parameter int DATA_W       = 128,
    parameter bit FIRST_PRIO_D = 1'b1
) (
    input logic           clk,
    input logic           rst,
    mem_arbiter_if.slave  ic,
    mem_arbiter_if.slave  dc,
    mem_arbiter_if.master mem
);
    typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, RELEASE} state_t;

    state_t            state;
    logic              last_d;
    logic              mem_read_q;
    logic              mem_write_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [DATA_W-1:0] ic_rdata_q;
    logic [DATA_W-1:0] dc_rdata_q;
    logic              ic_ready_q;
    logic              dc_ready_q;

    logic ic_pend;
    logic dc_pend;
    logic grant_d;

    assign ic_pend = ic.read | ic.write;
    assign dc_pend = dc.read | dc.write;
    // On a tie, D wins only if I was the last one served.
    assign grant_d = dc_pend & (~ic_pend | ~last_d);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            last_d      <= !FIRST_PRIO_D;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            ic_rdata_q  <= '0;
            dc_rdata_q  <= '0;
            ic_ready_q  <= 1'b0;
            dc_ready_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        state       <= SERVE_D;
                        last_d      <= 1'b1;
                        mem_read_q  <= dc.read;
                        mem_write_q <= dc.write;
                        mem_addr_q  <= dc.addr;
                        mem_wdata_q <= dc.wdata;
                    end else if (ic_pend) begin
                        state       <= SERVE_I;
                        last_d      <= 1'b0;
                        mem_read_q  <= ic.read;
                        mem_write_q <= ic.write;
                        mem_addr_q  <= ic.addr;
                        mem_wdata_q <= ic.wdata;
                    end
                end
                SERVE_I, SERVE_D: begin
                    // Requester inputs are deliberately ignored here; the command stays as latched.
                    if (mem.ready) begin
                        state       <= RELEASE;
                        mem_read_q  <= 1'b0;
                        mem_write_q <= 1'b0;
                        if (state == SERVE_D) begin
                            dc_rdata_q <= mem.rdata;
                            dc_ready_q <= 1'b1;
                        end else begin
                            ic_rdata_q <= mem.rdata;
                            ic_ready_q <= 1'b1;
                        end
                    end
                end
                RELEASE: begin
                    state      <= IDLE;
                    ic_ready_q <= 1'b0;
                    dc_ready_q <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign mem.read  = mem_read_q;
    assign mem.write = mem_write_q;
    assign mem.addr  = mem_addr_q;
    assign mem.wdata = mem_wdata_q;
    assign ic.rdata  = ic_rdata_q;
    assign ic.ready  = ic_ready_q;
    assign dc.rdata  = dc_rdata_q;
    assign dc.ready  = dc_ready_q;
endmodule
